reg_dump_unit: RTL and testbench

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_pkg.sv | 26 ++
 rtl/reg_dump_unit.sv | 139 +++++++++++++
 tb/tb_reg_dump_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
//   Shared definitions for reg_dump_unit: FSM state encoding, default
//   register count and a helper that tells whether a state owns read port A.
`timescale 1ns/1ps
package reg_dump_pkg;

  localparam int NREGS_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_ADDR = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // The unit owns the regfile read port (and halts the CPU) from the first
  // scan address until the next run is started.
  function automatic logic owns_port(input state_t st);
    case (st)
      ST_ADDR, ST_SEND, ST_DONE: owns_port = 1'b1;
      default:                   owns_port = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Lets the processor run for cfg_cycles cycles, then halts it, takes over
//   regfile read port A and streams every register out over a valid/ready
//   interface while accumulating a modulo-2^32 checksum.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   start, cfg_cycles : run request (IDLE/DONE only) and run length
//   cpu_rs1, rs1_out  : CPU read index in, muxed index out to the regfile
//   regA              : combinational regfile read data
//   test_mode         : unit owns read port A / processor halted
//   dump_valid/ready, dump_idx, dump_data : one beat per register
//   checksum, done    : running sum of dumped values, scan complete
`timescale 1ns/1ps
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int CYCW  = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [CYCW-1:0] cfg_cycles,
  input  logic [4:0]      cpu_rs1,
  output logic [4:0]      rs1_out,
  input  logic [31:0]     regA,
  output logic            test_mode,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_idx,
  output logic [31:0]     dump_data,
  output logic [31:0]     checksum,
  output logic            done
);

  localparam logic [4:0]      LAST_IDX = 5'(NREGS - 1);
  localparam logic [CYCW-1:0] CNT_ONE  = CYCW'(1'b1);
  localparam logic [CYCW-1:0] CNT_ZERO = {CYCW{1'b0}};

  state_t          state_r, state_nxt_s;
  logic [CYCW-1:0] cnt_r, cnt_nxt_s;
  logic [4:0]      idx_r, idx_nxt_s;
  logic [4:0]      dump_idx_r, dump_idx_nxt_s;
  logic [31:0]     dump_data_r, dump_data_nxt_s;
  logic [31:0]     checksum_r, checksum_nxt_s;
  logic            test_mode_r, dump_valid_r, done_r;

  // Next-state and datapath update for the run/scan sequence.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    idx_nxt_s       = idx_r;
    dump_idx_nxt_s  = dump_idx_r;
    dump_data_nxt_s = dump_data_r;
    checksum_nxt_s  = checksum_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_nxt_s      = cfg_cycles;
          idx_nxt_s      = 5'd0;
          checksum_nxt_s = 32'd0;
          // A zero-length run skips RUN entirely.
          if (cfg_cycles == CNT_ZERO) begin
            state_nxt_s = ST_ADDR;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        cnt_nxt_s = cnt_r - CNT_ONE;
        // "<=" keeps a corrupted zero count from stalling in RUN forever.
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_ADDR: begin
        // rs1_out already shows idx_r here, so regA is this register's value.
        dump_data_nxt_s = regA;
        dump_idx_nxt_s  = idx_r;
        checksum_nxt_s  = checksum_r + regA;
        state_nxt_s     = ST_SEND;
      end
      ST_SEND: begin
        if (dump_ready) begin
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_DONE;
          end else begin
            idx_nxt_s   = idx_r + 5'd1;
            state_nxt_s = ST_ADDR;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      idx_r        <= 5'd0;
      dump_idx_r   <= 5'd0;
      dump_data_r  <= 32'd0;
      checksum_r   <= 32'd0;
      test_mode_r  <= 1'b0;
      dump_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      dump_idx_r   <= dump_idx_nxt_s;
      dump_data_r  <= dump_data_nxt_s;
      checksum_r   <= checksum_nxt_s;
      test_mode_r  <= owns_port(state_nxt_s);
      dump_valid_r <= (state_nxt_s == ST_SEND);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

  assign rs1_out    = test_mode_r ? idx_r : cpu_rs1;
  assign test_mode  = test_mode_r;
  assign dump_valid = dump_valid_r;
  assign dump_idx   = dump_idx_r;
  assign dump_data  = dump_data_r;
  assign checksum   = checksum_r;
  assign done       = done_r;

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit
//   Self-checking bench for reg_dump_unit: a table of run configurations is
//   replayed against a behavioural regfile, expected beats go into a queue
//   when a run is started and are popped on every handshake; hand-written
//   sequences cover reset during a beat and recovery.
`timescale 1ns/1ps
module tb_reg_dump_unit;

  localparam int NREGS = 32;
  localparam int CYCW  = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [CYCW-1:0] cfg_cycles;
  logic [4:0]      cpu_rs1;
  logic [4:0]      rs1_out;
  logic [31:0]     regA;
  logic            test_mode;
  logic            dump_valid;
  logic            dump_ready;
  logic [4:0]      dump_idx;
  logic [31:0]     dump_data;
  logic [31:0]     checksum;
  logic            done;

  logic [31:0] rf [NREGS];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [CYCW-1:0] cfg;
    logic [4:0]      stall_idx;
    int              stall_len;
    int              pat;
    logic            mid_start;
    logic [31:0]     cks;
  } vec_t;

  beat_t q[$];
  vec_t  vecs[5];
  int    checks = 0;
  int    errors = 0;

  reg_dump_unit #(.NREGS(NREGS), .CYCW(CYCW)) dut (
    .clock(clock), .reset(reset), .start(start), .cfg_cycles(cfg_cycles),
    .cpu_rs1(cpu_rs1), .rs1_out(rs1_out), .regA(regA),
    .test_mode(test_mode), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .checksum(checksum), .done(done)
  );

  always #5 clock = ~clock;

  assign regA = rf[rs1_out];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_pattern(input int pat);
    for (int i = 0; i < NREGS; i++) begin
      case (pat)
        0:       rf[i] = 32'(i * 3);
        1:       rf[i] = 32'h1000_0001 * 32'(i);
        default: rf[i] = (i == 0) ? 32'd0 : 32'hFFFF_FFFF;
      endcase
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},  {31'd0, dump_valid}, 32'd0);
    chk({tag, "_tmode"},  {31'd0, test_mode},  32'd0);
    chk({tag, "_done"},   {31'd0, done},       32'd0);
    chk({tag, "_idx"},    {27'd0, dump_idx},   32'd0);
    chk({tag, "_data"},   dump_data,           32'd0);
    chk({tag, "_cks"},    checksum,            32'd0);
    chk({tag, "_rs1"},    {27'd0, rs1_out},    {27'd0, cpu_rs1});
  endtask

  task automatic run_scan(input vec_t v);
    beat_t e;
    int    k, beats, last_hs, stalled, gap;
    bit    seen_tm;
    load_pattern(v.pat);
    q.delete();
    for (int i = 0; i < NREGS; i++) q.push_back({5'(i), rf[i]});
    @(negedge clock);
    start = 1'b1; cfg_cycles = v.cfg; dump_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_cks_clear", checksum, 32'd0);
    chk("start_done_low", {31'd0, done}, 32'd0);
    chk("start_valid_low", {31'd0, dump_valid}, 32'd0);
    if (v.cfg != '0) chk("run_rs1_cpu", {27'd0, rs1_out}, {27'd0, cpu_rs1});
    seen_tm = 1'b0; beats = 0; stalled = 0; last_hs = -1; k = 0;
    while (k < 400 && beats < NREGS) begin
      if (k > 0) @(negedge clock);
      start = 1'b0;
      if (v.mid_start && (k == 1 || beats == 10)) start = 1'b1;
      if (!seen_tm && test_mode) begin
        chk("tmode_rise_cycle", 32'(k), 32'(v.cfg));
        seen_tm = 1'b1;
      end
      dump_ready = 1'b1;
      if (dump_valid && dump_idx == v.stall_idx && stalled < v.stall_len) begin
        dump_ready = 1'b0;
        stalled++;
        if (q.size() > 0) begin
          chk("stall_idx_held", {27'd0, dump_idx}, {27'd0, q[0].idx});
          chk("stall_data_held", dump_data, q[0].data);
        end
      end
      if (dump_valid && dump_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {27'd0, dump_idx}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("beat_idx", {27'd0, dump_idx}, {27'd0, e.idx});
          chk("beat_data", dump_data, e.data);
          if (last_hs >= 0) begin
            gap = 2 + ((e.idx == v.stall_idx) ? v.stall_len : 0);
            chk("beat_gap", 32'(k - last_hs), 32'(gap));
          end
        end
        last_hs = k;
        beats++;
      end
      k++;
    end
    start = 1'b0;
    chk("beat_count", 32'(beats), 32'(NREGS));
    @(negedge clock);
    chk("done_flag", {31'd0, done}, 32'd1);
    chk("done_tmode", {31'd0, test_mode}, 32'd1);
    chk("done_valid_low", {31'd0, dump_valid}, 32'd0);
    chk("final_checksum", checksum, v.cks);
    chk("queue_empty", 32'(q.size()), 32'd0);
    // DONE must hold without a new start.
    repeat (3) @(negedge clock);
    chk("done_hold", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int k;
    vecs[0] = '{cfg: 10'd5, stall_idx: 5'd7,  stall_len: 0, pat: 0, mid_start: 1'b0, cks: 32'd1488};
    vecs[1] = '{cfg: 10'd5, stall_idx: 5'd7,  stall_len: 4, pat: 0, mid_start: 1'b0, cks: 32'd1488};
    vecs[2] = '{cfg: 10'd0, stall_idx: 5'd31, stall_len: 0, pat: 1, mid_start: 1'b1, cks: 32'h0000_01F0};
    vecs[3] = '{cfg: 10'd1, stall_idx: 5'd0,  stall_len: 2, pat: 2, mid_start: 1'b0, cks: 32'hFFFF_FFE1};
    vecs[4] = '{cfg: 10'd3, stall_idx: 5'd31, stall_len: 3, pat: 0, mid_start: 1'b1, cks: 32'd1488};

    reset = 1'b0; start = 1'b0; cfg_cycles = '0; cpu_rs1 = 5'd19; dump_ready = 1'b0;
    load_pattern(0);
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("idle");

    for (int n = 0; n < 5; n++) run_scan(vecs[n]);

    // Reset while beat 12 is on the bus, with ready high: the beat must be lost.
    load_pattern(0);
    start = 1'b1; cfg_cycles = 10'd2; dump_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!(dump_valid && dump_idx == 5'd12) && k < 300) begin
      @(negedge clock);
      k++;
    end
    chk("reach_idx12", {31'd0, (k < 300)}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("rst_send");
    cpu_rs1 = 5'd7;
    #1;
    chk("rst_rs1_follow", {27'd0, rs1_out}, 32'd7);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("post_rst_valid", {31'd0, dump_valid}, 32'd0);
      chk("post_rst_tmode", {31'd0, test_mode}, 32'd0);
    end

    // Full run from IDLE after the abort.
    run_scan(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
